// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI response transmitter
//
// Contents:
//   state_t       transmitter FSM states
//   ERR_FILL      bit value replicated to form the error word (all ones)
//   CMD_SRC_FIRST command code that selects source 0; code k selects source k-1
//   cmd_is_legal  true when a command byte names an existing source
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SRC = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic       ERR_FILL      = 1'b1;
  localparam logic [7:0] CMD_SRC_FIRST = 8'd1;

  function automatic logic cmd_is_legal(input logic [7:0] cmd, input int num_src);
    return (cmd >= CMD_SRC_FIRST) && (int'(cmd) <= num_src);
  endfunction

endpackage

// File: rtl/spi_piso_sr.sv
// rtl/spi_piso_sr.sv - MSB-first parallel-in serial-out shift register, fills with ones
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset (register resets to all ones)
//   load       parallel load of load_data (has priority over shift)
//   load_data  word to load
//   shift      shift left by one, inserting a 1 at the LSB
//   msb        current most significant bit
module spi_piso_sr #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  output logic              msb
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= '1;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[DATA_W-2:0], 1'b1};
    end
  end

  assign msb = sr[DATA_W-1];

endmodule

// File: rtl/spi_response_tx.sv
// rtl/spi_response_tx.sv - SPI slave response transmitter with source select and timeout
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   SCK, SS    raw SPI clock / active-low select from the master (async to clk)
//   cmd_valid  one-cycle strobe, cmd holds a received command byte
//   cmd        command byte, k in 1..NUM_SRC selects source k-1
//   auto_send  one-cycle strobe, queue source 0 without a command
//   src_data   packed source words, source i at [i*DATA_W +: DATA_W]
//   src_valid  per-source data-ready levels
//   MISO       serial data MSB first, Z while synchronised SS is high
//   tx_busy    word loaded and not yet fully shifted out
//   tx_done    one-cycle pulse after the last bit
//   err_flag   sticky error indication, cleared by the next legal command
module spi_response_tx
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_SRC  = 2,
  parameter int WAIT_MAX = 255
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      SCK,
  input  logic                      SS,
  input  logic                      cmd_valid,
  input  logic [7:0]                cmd,
  input  logic                      auto_send,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic                      MISO,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      err_flag
);

  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t state, state_n;

  logic sck_meta, sck_sync, sck_prev;
  logic ss_meta, ss_sync, ss_prev;

  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic [SEL_W-1:0]  sel, sel_n;
  logic              load_err, load_err_n;
  logic              err_n;

  logic              sr_load, sr_shift, sr_msb;
  logic [DATA_W-1:0] sr_data;
  logic [DATA_W-1:0] src_word;

  logic sck_fall, ss_rise;

  // SS resets high so MISO stays tri-stated until SS is seen low after reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
      ss_meta  <= 1'b1;
      ss_sync  <= 1'b1;
      ss_prev  <= 1'b1;
    end else begin
      sck_meta <= SCK;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
      ss_meta  <= SS;
      ss_sync  <= ss_meta;
      ss_prev  <= ss_sync;
    end
  end

  assign sck_fall = sck_prev & ~sck_sync;
  assign ss_rise  = ~ss_prev & ss_sync;
  assign src_word = src_data[sel*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      sel      <= '0;
      load_err <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      wait_cnt <= wait_cnt_n;
      sel      <= sel_n;
      load_err <= load_err_n;
      err_flag <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    wait_cnt_n = wait_cnt;
    sel_n      = sel;
    load_err_n = load_err;
    err_n      = err_flag;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    sr_data    = {DATA_W{ERR_FILL}};

    case (state)
      ST_IDLE: begin
        // auto_send outranks a simultaneous command, which is then dropped.
        if (auto_send) begin
          state_n    = ST_LOAD;
          sel_n      = '0;
          load_err_n = 1'b0;
        end else if (cmd_valid) begin
          if (cmd_is_legal(cmd, NUM_SRC)) begin
            state_n    = ST_WAIT_SRC;
            sel_n      = SEL_W'(cmd - CMD_SRC_FIRST);
            load_err_n = 1'b0;
            wait_cnt_n = '0;
            err_n      = 1'b0;
          end else begin
            state_n    = ST_LOAD;
            load_err_n = 1'b1;
          end
        end
      end

      ST_WAIT_SRC: begin
        if (src_valid[sel]) begin
          state_n = ST_LOAD;
        end else if (wait_cnt == WAIT_W'(WAIT_MAX)) begin
          state_n    = ST_LOAD;
          load_err_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end

      ST_LOAD: begin
        sr_load   = 1'b1;
        sr_data   = load_err ? {DATA_W{ERR_FILL}} : src_word;
        bit_cnt_n = '0;
        if (load_err) begin
          err_n = 1'b1;
        end
        state_n = ST_SHIFT;
      end

      ST_SHIFT: begin
        // Master dropping SS aborts the word; park the register at idle ones.
        if (ss_rise) begin
          state_n = ST_IDLE;
          sr_load = 1'b1;
        end else if (sck_fall && !ss_sync) begin
          sr_shift  = 1'b1;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_n = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  spi_piso_sr #(
    .DATA_W(DATA_W)
  ) u_sr (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (sr_load),
    .load_data (sr_data),
    .shift     (sr_shift),
    .msb       (sr_msb)
  );

  assign tx_busy = (state == ST_LOAD) || (state == ST_SHIFT);
  assign tx_done = (state == ST_DONE);
  assign MISO    = ss_sync ? 1'bz : sr_msb;

endmodule

// File: doc/spi_response_tx.md
SPI_RESPONSE_TX -- requirements
Module: spi_response_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of one response word shifted out on MISO.
REQ-002 Parameter NUM_SRC, default 2: number of selectable response sources (source 0 = detected digit, source 1 = cost).
REQ-003 Parameter WAIT_MAX, default 255: cycles the block waits for a requested source before sending the error word.
REQ-004 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 SCK  input  1  raw SPI serial clock from the master (mode 0), asynchronous to clk.
REQ-007 SS  input  1  raw active-low slave select, asynchronous to clk.
REQ-008 cmd_valid  input  1  one-cycle strobe: cmd holds a completed command byte from the SPI receiver.
REQ-009 cmd  input  8  command byte: value k in 1..NUM_SRC requests source k-1; any other value is illegal.
REQ-010 auto_send  input  1  one-cycle strobe (network done): queue source 0 without a command.
REQ-011 src_data  input  NUM_SRC*DATA_W  packed source words; source i occupies bits [i*DATA_W +: DATA_W].
REQ-012 src_valid  input  NUM_SRC  per-source data-ready flags, level-sensitive.
REQ-013 MISO  output  1  serial data, MSB first; high-impedance whenever synchronised SS is high.
REQ-014 tx_busy  output  1  high from word load until the last bit has shifted out.
REQ-015 tx_done  output  1  one-cycle pulse after the final bit of a word has shifted out.
REQ-016 err_flag  output  1  sticky; set when the error word is sent; cleared by the next legal cmd_valid.

Function
REQ-017 SCK and SS shall each pass through a two-flop synchroniser; SCK edges shall be detected from the synchronised copy (rise = prev 0, now 1).
REQ-018 States: IDLE, WAIT_SRC, LOAD, SHIFT, DONE.
REQ-019 IDLE: auto_send -> LOAD with sel=0; else legal cmd_valid -> WAIT_SRC with sel=cmd-1; else illegal cmd_valid -> LOAD with the error word; auto_send and cmd_valid in the same cycle -> auto_send wins and the command is dropped.
REQ-020 WAIT_SRC: if src_valid[sel]=1 -> LOAD; the wait counter increments each cycle; when it reaches WAIT_MAX -> LOAD with the error word (all ones).
REQ-021 LOAD: exactly one cycle; the shift register takes the selected word (or all ones); the bit counter clears; next state SHIFT.
REQ-022 SHIFT: MISO = shift register MSB; on each synchronised SCK falling edge with SS low, shift left by one, fill with 1, and increment the bit counter; after DATA_W falling edges -> DONE.
REQ-023 DONE: assert tx_done for one cycle; next state IDLE.
REQ-024 SS rising (deassert) during SHIFT shall abort the word: next state IDLE, no tx_done pulse, and the shift register is set to all ones.
REQ-025 cmd_valid and auto_send arriving outside IDLE shall be ignored.
REQ-026 tx_busy = (state is LOAD or SHIFT); in IDLE the shift register holds all ones, so an idle read returns 0xFF (DATA_W ones).
REQ-027 Bit counter width = $clog2(DATA_W+1); wait counter width = $clog2(WAIT_MAX+1); neither counter wraps.

Reset
REQ-028 On n_rst low: state IDLE, shift register all ones, both counters 0, sel 0, tx_done 0, err_flag 0, synchroniser flops 1 (SS) and 0 (SCK).
REQ-029 Reset asserted mid-word shall abort immediately; MISO is Z until SS is seen low after reset.

Structure
REQ-030 Package spi_pkg shall hold the state enum and the error-word and command-code constants.
REQ-031 The shift register shall be one sub-module, spi_piso_sr (parameter DATA_W, load, shift, MSB-first, fill 1); the FSM, counters and synchronisers stay in the top module.

Verification
REQ-032 auto_send with src_data[7:0]=0x07, then 8 SCK cycles with SS low -> MISO bits 0,0,0,0,0,1,1,1; tx_done pulses once.
REQ-033 cmd=0x02 with src_valid[1] raised 10 cycles later, cost word 0xA5 -> 0xA5 shifted out; err_flag 0.
REQ-034 cmd=0x02 with src_valid held 0 for WAIT_MAX+5 cycles -> 0xFF shifted out; err_flag 1.
REQ-035 cmd=0x09 (illegal) -> 0xFF shifted out and err_flag set; then legal cmd=0x01 -> err_flag cleared.
REQ-036 SS deasserted after 3 SCK edges -> IDLE, no tx_done; next read returns the full new word; MISO is Z while SS is high.
REQ-037 n_rst pulsed mid-SHIFT -> all outputs at reset values within one cycle; DATA_W=16 build passes REQ-032 with a 16-bit word.
